cp0_exc_ctrl: RTL
=================

// Module: cp0_exc_ctrl
// PURPOSE
//  Parametrised MIPS32 CP0 register file plus exception/interrupt controller. Sits beside the MEM stage:
//  - commits exceptions and ERET;
//  - generates the pipeline flush and redirect PC;
//  - arbitrates hardware and timer interrupts through Status.IM/IE/EXL;
//  - serves MFC0/MTC0.
//  Adds to the previous CP0: Count prescaler, EXL-protected EPC, interrupt pending output and registered flush/redirect.
// PARAMETERS
//  HW_INT_N   6             number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_N-1:2]
//  COUNT_DIV  2             Count increments once every COUNT_DIV clocks (1..16)
//  EXC_VECTOR 32'hBFC00380  redirect PC on exception entry
//  PRID_VAL   32'h004C0102  read-only PRId value
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous reset, active-high
//  we           in   1         MTC0 write enable
//  waddr        in   5         MTC0 register number
//  wdata        in   32        MTC0 data
//  raddr        in   5         MFC0 register number
//  rdata        out  32        MFC0 data (combinational)
//  hw_int       in   HW_INT_N  level-sensitive hardware interrupts
//  exc_valid    in   1         commit exception this cycle
//  exc_code     in   5         ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
//  exc_pc       in   32        PC of faulting instruction
//  exc_in_ds    in   1         faulting instruction is in a delay slot
//  exc_badvaddr in   32        faulting address (codes 4/5 only)
//  eret         in   1         commit ERET this cycle
//  int_pending  out  1         an enabled interrupt is pending; MEM stage raises exc_code 0
//  flush        out  1         registered one-cycle pipeline flush
//  flush_pc     out  32        redirect PC, valid while flush=1
//  status_o     out  32        Status value (live)
//  cause_o      out  32        Cause value (live)
//  epc_o        out  32        EPC value (live)
// BEHAVIOUR
//  Reset values:
//  - Count=0, Compare=0, Status=32'h1040_0000 (CU0=1, BEV=1, EXL=0, IE=0, IM=0), Cause=0, EPC=0, BadVAddr=0.
//  - Prescaler=0, TI=0, flush=0, flush_pc=0.
//  - int_pending=0, because IE=0 at reset.
//  Registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId.
//  Unlisted read addresses return 0. Unlisted write addresses are ignored.
//  Count:
//  - Prescaler counts 0..COUNT_DIV-1; Count+=1 when prescaler==COUNT_DIV-1.
//  - Count wraps 32'hFFFFFFFF->0.
//  - An MTC0 to Count loads wdata and clears the prescaler; that write wins over the increment.
//  Timer:
//  - TI (Cause[30]) sets on the clock after Count==Compare while Compare!=0.
//  - An MTC0 to Compare clears TI. If a set and a clear happen in the same cycle, the clear wins.
//  Cause:
//  - Cause.IP[7:2]={TI|hw_int[5], hw_int[4:0]}, sampled every cycle; unused lines read 0.
//  - Writable fields: IP[1:0] (software interrupts), IV[23], DC[27].
//  Status writable fields: IM[15:8], EXL[1], IE[0]. All other Status bits are read-only.
//  int_pending = IE & ~EXL & |(Cause.IP & Status.IM). Combinational from registered state.
//  Commit priority: exc_valid > eret > MTC0. A lower-priority action in the same cycle is dropped entirely.
//  Exception commit (exc_valid=1):
//  - If EXL==0: EPC=exc_in_ds ? exc_pc-4 : exc_pc, and BD=exc_in_ds.
//  - If EXL==1: EPC and BD are unchanged.
//  - Then EXL=1 and ExcCode=exc_code. BadVAddr=exc_badvaddr only for codes 4 and 5.
//  - Next clock: flush=1 and flush_pc=EXC_VECTOR.
//  ERET commit: EXL=0. Next clock: flush=1 and flush_pc=EPC (the value before the commit edge).
//  flush is high for exactly one cycle. It cannot re-trigger without a new exc_valid/eret.
//  Read path:
//  - rdata shows the current register contents.
//  - A same-cycle MTC0 to raddr returns the OLD value; there is no bypass.
//  - Cause reads show live IP bits.
//  Reset mid-operation: a pending flush, TI or prescaler phase is discarded, and all state returns to reset values on that edge.
// TESTING
//  T1 COUNT_DIV=2: deassert rst -> Count reads 1 after 2 clocks and 5 after 10 clocks. MTC0 Count=FFFFFFFE -> Count reads 0 after 4 clocks (wrap).
//  T2 Timer: Compare=20, IM7=1, IE=1 -> TI=1 and int_pending=1 one clock after Count==20. MTC0 Compare=40 -> TI=0 next clock.
//  T3 Exception in delay slot: exc_valid, code 4, pc=BFC00104, ds=1, badvaddr=0000_0003.
//     -> EPC=BFC00100, BD=1, ExcCode=4, BadVAddr=3, EXL=1.
//     -> flush=1 with flush_pc=BFC00380 for exactly one clock.
//  T4 Nested exception: with EXL=1, exc_valid code 8, pc=BFC00200 -> EPC unchanged and ExcCode=8. ERET -> flush_pc=the old EPC, EXL=0.
//  T5 Collision: exc_valid, eret and an MTC0 Status=0 in the same cycle -> only the exception takes effect. Status.IM is unchanged and EXL=1.
//  T6 Interrupt masking: hw_int[2]=1 with IM4=1, IE=1 -> int_pending=1. EXL=1 or IM4=0 -> int_pending=0.
//     Reset asserted the cycle after exc_valid -> flush stays 0.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: MIPS32 CP0 register file with exception, ERET and interrupt
// control. Commits exceptions/ERET from the MEM stage, produces a registered
// one-cycle flush with its redirect PC, runs a prescaled Count/Compare timer
// and serves MFC0/MTC0 accesses.
module cp0_exc_ctrl #(
  parameter int          HW_INT_N   = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  output logic [31:0]         rdata,
  input  logic [HW_INT_N-1:0] hw_int,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_in_ds,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  output logic                int_pending,
  output logic                flush,
  output logic [31:0]         flush_pc,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [4:0]  REG_PRID     = 5'd15;

  // CU0 and BEV set; IM, EXL and IE are the only software-writable bits
  localparam logic [31:0] STATUS_RESET = 32'h1040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam logic [4:0]  PRESC_MAX    = 5'(COUNT_DIV - 1);

  logic [31:0] r_count;
  logic [4:0]  r_prescaler;
  logic [31:0] r_compare;
  logic        r_ti;
  logic [31:0] r_status;
  logic        r_bd;
  logic [4:0]  r_excCode;
  logic [1:0]  r_ipSw;
  logic        r_iv;
  logic        r_dc;
  logic [31:0] r_epc;
  logic [31:0] r_badVAddr;
  logic        r_flush;
  logic [31:0] r_flushPc;

  logic        w_mtc0;
  logic        w_eretCommit;
  logic        w_wrCount;
  logic        w_wrCompare;
  logic        w_wrStatus;
  logic        w_wrCause;
  logic        w_wrEpc;
  logic [5:0]  w_hwExt;
  logic [7:0]  w_ip;
  logic [31:0] w_cause;
  logic        w_exl;

  // An exception drops any ERET or MTC0 in the same cycle; ERET drops MTC0
  assign w_mtc0       = we & ~exc_valid & ~eret;
  assign w_eretCommit = eret & ~exc_valid;
  assign w_wrCount    = w_mtc0 && (waddr == REG_COUNT);
  assign w_wrCompare  = w_mtc0 && (waddr == REG_COMPARE);
  assign w_wrStatus   = w_mtc0 && (waddr == REG_STATUS);
  assign w_wrCause    = w_mtc0 && (waddr == REG_CAUSE);
  assign w_wrEpc      = w_mtc0 && (waddr == REG_EPC);
  assign w_exl        = r_status[1];

  // Zero-extend the hardware interrupt lines to the six IP[7:2] slots
  always_comb begin
    w_hwExt                 = '0;
    w_hwExt[HW_INT_N-1:0]   = hw_int;
  end

  assign w_ip    = {r_ti | w_hwExt[5], w_hwExt[4:0], r_ipSw};
  assign w_cause = {r_bd, r_ti, 2'b00, r_dc, 3'b000, r_iv, 7'b0,
                    w_ip, 1'b0, r_excCode, 2'b00};

  // Prescaled Count; an MTC0 to Count reloads it and restarts the prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_prescaler <= '0;
    end else if (w_wrCount) begin
      r_count     <= wdata;
      r_prescaler <= '0;
    end else if (r_prescaler == PRESC_MAX) begin
      r_count     <= r_count + 32'd1;
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + 5'd1;
    end
  end

  // Compare register and timer interrupt; a Compare write beats a match
  always_ff @(posedge clk) begin
    if (rst) begin
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wrCompare) begin
        r_compare <= wdata;
      end
      if (w_wrCompare) begin
        r_ti <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_ti <= 1'b1;
      end
    end
  end

  // Status: exception sets EXL, ERET clears it, MTC0 touches only IM/EXL/IE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= STATUS_RESET;
    end else if (exc_valid) begin
      r_status[1] <= 1'b1;
    end else if (w_eretCommit) begin
      r_status[1] <= 1'b0;
    end else if (w_wrStatus) begin
      r_status <= (r_status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
    end
  end

  // Exception state: EPC/BD are frozen while EXL is already set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc      <= '0;
      r_bd       <= 1'b0;
      r_excCode  <= '0;
      r_badVAddr <= '0;
      r_ipSw     <= '0;
      r_iv       <= 1'b0;
      r_dc       <= 1'b0;
    end else if (exc_valid) begin
      if (!w_exl) begin
        r_epc <= exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
        r_bd  <= exc_in_ds;
      end
      r_excCode <= exc_code;
      if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
        r_badVAddr <= exc_badvaddr;
      end
    end else begin
      if (w_wrCause) begin
        r_ipSw <= wdata[9:8];
        r_iv   <= wdata[23];
        r_dc   <= wdata[27];
      end
      if (w_wrEpc) begin
        r_epc <= wdata;
      end
    end
  end

  // Registered one-shot flush; ERET redirects to the pre-commit EPC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush   <= 1'b0;
      r_flushPc <= '0;
    end else begin
      r_flush <= exc_valid | eret;
      if (exc_valid) begin
        r_flushPc <= EXC_VECTOR;
      end else if (eret) begin
        r_flushPc <= r_epc;
      end
    end
  end

  // MFC0 read mux straight from the registers, no write bypass
  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = r_badVAddr;
      REG_COUNT:    rdata = r_count;
      REG_COMPARE:  rdata = r_compare;
      REG_STATUS:   rdata = r_status;
      REG_CAUSE:    rdata = w_cause;
      REG_EPC:      rdata = r_epc;
      REG_PRID:     rdata = PRID_VAL;
      default:      rdata = '0;
    endcase
  end

  assign int_pending = r_status[0] & ~w_exl & (|(w_ip & r_status[15:8]));
  assign flush       = r_flush;
  assign flush_pc    = r_flushPc;
  assign status_o    = r_status;
  assign cause_o     = w_cause;
  assign epc_o       = r_epc;

endmodule
